fetch_ir: RTL and testbench

Instruction fetch and instruction-register stage. It holds the program counter and issues single-outstanding word reads to instruction memory. Returned 16-bit instructions go into a 2-entry buffer. The head entry is presented to decode with its fields already split, and the `imm8` field feeds the 8-to-16 load-upper-immediate shifter and the other immediate paths directly.

---
 rtl/fetch_ir_if.sv | 32 +++
 rtl/fetch_ir.sv | 187 ++++++++++++++++++
 tb/tb_fetch_ir.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ir_if.sv
// Fetch-stage bundle: instruction-memory read port, redirect input and the
// decoded head-of-buffer presentation to decode.
interface fetch_ir_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_in;
    logic              ir_valid;
    logic              ir_ready;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic [3:0]        opcode;
    logic [3:0]        rd;
    logic [7:0]        imm8;

    // Fetch stage side
    modport master (
        output mem_req, mem_addr, ir_valid, ir, ir_pc, opcode, rd, imm8,
        input  mem_ack, mem_rdata, pc_load, pc_in, ir_ready
    );

    // Memory / decode / redirect side
    modport slave (
        input  mem_req, mem_addr, ir_valid, ir, ir_pc, opcode, rd, imm8,
        output mem_ack, mem_rdata, pc_load, pc_in, ir_ready
    );
endinterface

// File: rtl/fetch_ir.sv
// Instruction fetch + instruction register. Single outstanding word read,
// 2-entry FIFO of {instruction, address}; the head entry is held in a
// register so decode fields are plain slices of it.
module fetch_ir #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic       CLK,
    input  logic       Reset,
    fetch_ir_if.master bus
);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    state_t            state_r, state_next_s;
    logic [ADDR_W-1:0] pc_r, pc_next_s;
    logic [ADDR_W-1:0] addr_r, addr_next_s;
    logic [1:0]        count_r, count_next_s, count_after_pop_s;
    logic              drop_r, drop_next_s;
    logic              mem_req_r, mem_req_next_s;
    logic              ir_valid_r, ir_valid_next_s;
    logic [DATA_W-1:0] head_data_r, head_data_next_s, tail_data_r, tail_data_next_s;
    logic [ADDR_W-1:0] head_pc_r, head_pc_next_s, tail_pc_r, tail_pc_next_s;
    logic              pop_s, ack_s, push_s;

    // Event decode: redirect suppresses both pop and push on its edge
    always_comb begin
        pop_s             = ir_valid_r & bus.ir_ready & ~bus.pc_load;
        ack_s             = (state_r == ST_REQ) & bus.mem_ack;
        push_s            = ack_s & ~drop_r & ~bus.pc_load;
        count_after_pop_s = count_r - {1'b0, pop_s};
        if (bus.pc_load) begin
            count_next_s = 2'd0;
        end else begin
            count_next_s = count_after_pop_s + {1'b0, push_s};
        end
    end

    // Request FSM state register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request FSM next state: keep requesting while the buffer has room
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.pc_load || (count_next_s < 2'd2)) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.mem_ack && !bus.pc_load && !drop_r && (count_next_s == 2'd2)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath next values: pc, request address, drop flag and buffer shift
    always_comb begin
        pc_next_s        = pc_r;
        addr_next_s      = addr_r;
        drop_next_s      = drop_r;
        head_data_next_s = head_data_r;
        head_pc_next_s   = head_pc_r;
        tail_data_next_s = tail_data_r;
        tail_pc_next_s   = tail_pc_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.pc_load) begin
                    pc_next_s   = bus.pc_in;
                    addr_next_s = bus.pc_in;
                end else if (state_next_s == ST_REQ) begin
                    addr_next_s = pc_r;
                end else begin
                    addr_next_s = addr_r;
                end
            end
            ST_REQ: begin
                if (bus.pc_load) begin
                    pc_next_s = bus.pc_in;
                    if (bus.mem_ack) begin
                        // in-flight word discarded, new target issued at once
                        addr_next_s = bus.pc_in;
                        drop_next_s = 1'b0;
                    end else begin
                        // address must stay stable, so discard the late ack instead
                        drop_next_s = 1'b1;
                    end
                end else if (bus.mem_ack) begin
                    if (drop_r) begin
                        drop_next_s = 1'b0;
                        addr_next_s = pc_r;
                    end else begin
                        pc_next_s = addr_r + ADDR_ONE;
                        if (state_next_s == ST_REQ) begin
                            addr_next_s = addr_r + ADDR_ONE;
                        end else begin
                            addr_next_s = addr_r;
                        end
                    end
                end else begin
                    addr_next_s = addr_r;
                end
            end
            default: begin
                pc_next_s   = pc_r;
                addr_next_s = addr_r;
            end
        endcase

        // Pop shifts the tail into the head; an emptied head keeps its value
        if (pop_s && (count_r == 2'd2)) begin
            head_data_next_s = tail_data_r;
            head_pc_next_s   = tail_pc_r;
        end else begin
            head_data_next_s = head_data_r;
            head_pc_next_s   = head_pc_r;
        end

        if (push_s) begin
            if (count_after_pop_s == 2'd0) begin
                head_data_next_s = bus.mem_rdata;
                head_pc_next_s   = addr_r;
            end else begin
                tail_data_next_s = bus.mem_rdata;
                tail_pc_next_s   = addr_r;
            end
        end else begin
            tail_data_next_s = tail_data_r;
            tail_pc_next_s   = tail_pc_r;
        end

        mem_req_next_s  = (state_next_s == ST_REQ);
        ir_valid_next_s = (count_next_s != 2'd0);
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pc_r        <= RESET_PC;
            addr_r      <= {ADDR_W{1'b0}};
            count_r     <= 2'd0;
            drop_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            ir_valid_r  <= 1'b0;
            head_data_r <= {DATA_W{1'b0}};
            head_pc_r   <= {ADDR_W{1'b0}};
            tail_data_r <= {DATA_W{1'b0}};
            tail_pc_r   <= {ADDR_W{1'b0}};
        end else begin
            pc_r        <= pc_next_s;
            addr_r      <= addr_next_s;
            count_r     <= count_next_s;
            drop_r      <= drop_next_s;
            mem_req_r   <= mem_req_next_s;
            ir_valid_r  <= ir_valid_next_s;
            head_data_r <= head_data_next_s;
            head_pc_r   <= head_pc_next_s;
            tail_data_r <= tail_data_next_s;
            tail_pc_r   <= tail_pc_next_s;
        end
    end

    assign bus.mem_req  = mem_req_r;
    assign bus.mem_addr = addr_r;
    assign bus.ir_valid = ir_valid_r;
    assign bus.ir       = head_data_r;
    assign bus.ir_pc    = head_pc_r;
    assign bus.opcode   = head_data_r[15:12];
    assign bus.rd       = head_data_r[11:8];
    assign bus.imm8     = head_data_r[7:0];
endmodule

// File: tb/tb_fetch_ir.sv
// Randomized bench for fetch_ir against a queue-based transaction model.
module tb_fetch_ir;
    logic CLK;
    logic Reset;
    fetch_ir_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    fetch_ir #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // model state
    logic        m_req;
    logic [15:0] m_addr, m_pc;
    bit          m_drop;
    logic [31:0] q[$];
    logic [31:0] m_last;

    // memory driver state
    int wait_cnt = 0;
    int cur_lat  = 0;
    int fixed_lat = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'd0:   return 16'hA137;
            16'd1:   return 16'h2315;
            16'd2:   return 16'h30FF;
            default: return (a * 16'h9E37) ^ 16'h5A5A;
        endcase
    endfunction

    task automatic model_reset();
        m_req  = 1'b0;
        m_addr = 16'h0000;
        m_pc   = 16'h0000;
        m_drop = 1'b0;
        q.delete();
        m_last = 32'h0;
    endtask

    // one clock edge of the fetch stage, in transaction terms
    task automatic model_step();
        bit pop;
        pop = (q.size() > 0) && bus.ir_ready && !bus.pc_load;
        if (bus.pc_load) begin
            q.delete();
            m_pc = bus.pc_in;
            if (m_req && !bus.mem_ack) begin
                m_drop = 1'b1;
            end else begin
                m_req  = 1'b1;
                m_addr = bus.pc_in;
                m_drop = 1'b0;
            end
        end else begin
            if (pop) void'(q.pop_front());
            if (m_req && bus.mem_ack) begin
                if (m_drop) begin
                    m_drop = 1'b0;
                    m_addr = m_pc;
                end else begin
                    q.push_back({bus.mem_rdata, m_addr});
                    m_pc = m_addr + 16'd1;
                    if (q.size() < 2) m_addr = m_pc;
                    else m_req = 1'b0;
                end
            end else if (!m_req && q.size() < 2) begin
                m_req  = 1'b1;
                m_addr = m_pc;
            end
        end
        if (q.size() > 0) m_last = q[0];
    endtask

    task automatic compare_all();
        check_val("mem_req",  bus.mem_req,  m_req);
        check_val("mem_addr", bus.mem_addr, m_addr);
        check_val("ir_valid", bus.ir_valid, (q.size() > 0));
        check_val("ir",       bus.ir,       m_last[31:16]);
        check_val("ir_pc",    bus.ir_pc,    m_last[15:0]);
        check_val("opcode",   bus.opcode,   m_last[31:28]);
        check_val("rd",       bus.rd,       m_last[27:24]);
        check_val("imm8",     bus.imm8,     m_last[23:16]);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_mem_req"},  bus.mem_req,  32'h0);
        check_val({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        check_val({tag, "_ir_valid"}, bus.ir_valid, 32'h0);
        check_val({tag, "_ir"},       bus.ir,       32'h0);
        check_val({tag, "_ir_pc"},    bus.ir_pc,    32'h0);
        check_val({tag, "_opcode"},   bus.opcode,   32'h0);
        check_val({tag, "_rd"},       bus.rd,       32'h0);
        check_val({tag, "_imm8"},     bus.imm8,     32'h0);
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare_all();
    endtask

    // memory responder: acks after cur_lat waiting cycles, random acks when idle
    task automatic drive_mem();
        if (bus.mem_req) begin
            if (wait_cnt == 0) cur_lat = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
            bus.mem_ack   = (wait_cnt >= cur_lat);
            wait_cnt      = bus.mem_ack ? 0 : wait_cnt + 1;
            bus.mem_rdata = bus.mem_ack ? mem_word(bus.mem_addr) : 16'($urandom);
        end else begin
            bus.mem_ack   = ($urandom_range(0, 3) == 0);
            wait_cnt      = 0;
            bus.mem_rdata = 16'($urandom);
        end
    endtask

    // asynchronous reset asserted between clock edges, released on a falling edge
    task automatic do_reset(input string tag);
        #2;
        Reset = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        wait_cnt     = 0;
        bus.mem_ack  = 1'b0;
        bus.pc_load  = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b1;
    endtask

    logic [15:0] got_addr[3], got_ir[3], got_pc[3], got_fld[3];
    logic [15:0] exp_word[3] = '{16'hA137, 16'h2315, 16'h30FF};
    int n_a, n_i;
    bit redirected, found;
    logic [15:0] first_pc;

    initial begin
        Reset         = 1'b1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        bus.pc_load   = 1'b0;
        bus.pc_in     = 16'h0000;
        bus.ir_ready  = 1'b0;
        model_reset();
        @(negedge CLK);

        // reset then stream
        do_reset("rst0");
        fixed_lat    = 0;
        bus.ir_ready = 1'b1;
        n_a = 0;
        n_i = 0;
        for (int i = 0; i < 6; i++) begin
            drive_mem();
            if (bus.mem_req && bus.mem_ack && n_a < 3) begin
                got_addr[n_a] = bus.mem_addr;
                n_a++;
            end
            cycle();
            if (bus.ir_valid && n_i < 3) begin
                got_ir[n_i]  = bus.ir;
                got_pc[n_i]  = bus.ir_pc;
                got_fld[n_i] = {bus.opcode, bus.rd, bus.imm8};
                n_i++;
            end
        end
        check_val("stream_n_addr", n_a, 3);
        check_val("stream_n_ir", n_i, 3);
        for (int i = 0; i < 3; i++) begin
            check_val("stream_addr", got_addr[i], i);
            check_val("stream_ir", got_ir[i], exp_word[i]);
            check_val("stream_pc", got_pc[i], i);
            check_val("stream_fields", got_fld[i], exp_word[i]);
        end

        // backpressure
        do_reset("rst1");
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_mem();
            cycle();
        end
        check_val("bp_req_low", bus.mem_req, 1'b0);
        check_val("bp_ir_head", bus.ir, 16'hA137);
        check_val("bp_pc_head", bus.ir_pc, 16'h0000);
        drive_mem();
        bus.ir_ready = 1'b1;
        cycle();
        check_val("bp_req_again", bus.mem_req, 1'b1);
        check_val("bp_addr2", bus.mem_addr, 16'h0002);

        // slow memory, redirect while the read of 5 is pending
        fixed_lat  = 3;
        redirected = 1'b0;
        found      = 1'b0;
        first_pc   = 16'h0000;
        for (int i = 0; i < 120 && !found; i++) begin
            drive_mem();
            if (!redirected && bus.mem_req && bus.mem_addr == 16'd5 && !bus.mem_ack) begin
                bus.pc_load = 1'b1;
                bus.pc_in   = 16'h0040;
                redirected  = 1'b1;
            end else begin
                bus.pc_load = 1'b0;
            end
            cycle();
            if (redirected && !bus.pc_load && bus.ir_valid) begin
                found    = 1'b1;
                first_pc = bus.ir_pc;
            end
        end
        bus.pc_load = 1'b0;
        check_val("redir_seen", found, 1'b1);
        check_val("redir_first_pc", first_pc, 16'h0040);

        // redirect coincident with ack and pop, target wraps
        fixed_lat = 0;
        for (int i = 0; i < 8; i++) begin
            drive_mem();
            cycle();
        end
        drive_mem();
        if (bus.mem_req) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_word(bus.mem_addr);
        end
        wait_cnt     = 0;
        bus.ir_ready = 1'b1;
        bus.pc_load  = 1'b1;
        bus.pc_in    = 16'hFFFF;
        cycle();
        bus.pc_load = 1'b0;
        check_val("coinc_empty", bus.ir_valid, 1'b0);
        check_val("coinc_addr", bus.mem_addr, 16'hFFFF);
        drive_mem();
        cycle();
        check_val("wrap_addr", bus.mem_addr, 16'h0000);
        check_val("wrap_valid", bus.ir_valid, 1'b1);
        check_val("wrap_pc", bus.ir_pc, 16'hFFFF);

        // reset mid-stream, then random traffic
        do_reset("rst2");
        fixed_lat = -1;
        for (int i = 0; i < 1500; i++) begin
            drive_mem();
            bus.ir_ready = ($urandom_range(0, 3) != 0);
            bus.pc_load  = ($urandom_range(0, 24) == 0);
            bus.pc_in    = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            cycle();
        end
        bus.pc_load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
